// File: rtl/hybrid_buffer_writer.sv
// Write-side controller for the hybrid slot buffer: round-robin fill of the slot FIFOs, then a dump handshake.
// Optional build macro HYBRID_BUFFER_WRITER_BACKPRESSURE_EN lets per-slot full flags stall the input stream.
module hybrid_buffer_writer #(
   parameter int BUFFER_SLOTS        = 16,
   parameter int MAX_PULSES_PER_SLOT = 64,
   parameter int DATA_WIDTH          = 32,
   localparam int LIMIT_W            = $clog2(MAX_PULSES_PER_SLOT),
   localparam int IDX_W              = (BUFFER_SLOTS > 1) ? $clog2(BUFFER_SLOTS) : 1
) (
   input  logic                    core_clk,
   input  logic                    resetn,
   input  logic                    fill_start,
   input  logic [LIMIT_W-1:0]      fill_limit,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [BUFFER_SLOTS-1:0] slot_full,
   output logic [BUFFER_SLOTS-1:0] slot_write_en,
   output logic [DATA_WIDTH-1:0]   slot_write_data,
   output logic                    begin_dump,
   input  logic                    dump_done,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DUMP  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [LIMIT_W-1:0] fill_limit_q;
   logic [LIMIT_W-1:0] row_cnt;
   logic [IDX_W-1:0]   slot_idx;
   logic               slot_ready;
   logic               fill_ready;
   logic               accept;
   logic               start_fill;
   logic               slot_wrap;
   logic               last_beat;

`ifdef HYBRID_BUFFER_WRITER_BACKPRESSURE_EN
   // A full target slot holds the stream rather than skipping ahead, so row order is preserved.
   assign slot_ready = !slot_full[slot_idx];
`else
   logic unused_slot_full;
   assign unused_slot_full = ^slot_full;
   assign slot_ready       = 1'b1;
`endif

   assign fill_ready = (state_q == FILL) && slot_ready;
   assign in_ready   = fill_ready;
   assign accept     = in_valid && fill_ready;
   assign start_fill = (state_q == IDLE) && fill_start && (fill_limit != '0);
   assign slot_wrap  = (slot_idx == IDX_W'(BUFFER_SLOTS - 1));
   assign last_beat  = slot_wrap && (row_cnt == (fill_limit_q - LIMIT_W'(1)));

   always_ff @(posedge core_clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = (state_q != IDLE);
      case (state_q)
         IDLE:    if (start_fill) state_d = FILL;
         FILL:    if (accept && last_beat) state_d = DUMP;
         DUMP:    state_d = DRAIN;
         DRAIN:   if (dump_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // begin_dump is registered off DUMP so it trails the final FIFO write strobe by one cycle.
   always_ff @(posedge core_clk or negedge resetn) begin
      if (!resetn) begin
         fill_limit_q    <= '0;
         slot_idx        <= '0;
         row_cnt         <= '0;
         slot_write_en   <= '0;
         slot_write_data <= '0;
         begin_dump      <= 1'b0;
      end else begin
         begin_dump    <= (state_q == DUMP);
         slot_write_en <= '0;
         if (start_fill) begin
            fill_limit_q <= fill_limit;
            slot_idx     <= '0;
            row_cnt      <= '0;
         end else if (accept) begin
            slot_write_en   <= BUFFER_SLOTS'(1) << slot_idx;
            slot_write_data <= in_data;
            if (slot_wrap) begin
               slot_idx <= '0;
               row_cnt  <= row_cnt + LIMIT_W'(1);
            end else begin
               slot_idx <= slot_idx + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_hybrid_buffer_writer.sv
// Directed self-checking bench for hybrid_buffer_writer with a 4-slot configuration.
// Expected strobes and data are hand-derived from the round-robin fill order.
module tb_hybrid_buffer_writer;

   localparam int SLOTS = 4;
   localparam int MAXP  = 16;
   localparam int LW    = $clog2(MAXP);
   localparam int DW    = 32;

   logic             core_clk   = 1'b0;
   logic             resetn     = 1'b1;
   logic             fill_start = 1'b0;
   logic [LW-1:0]    fill_limit = '0;
   logic             in_valid   = 1'b0;
   logic [DW-1:0]    in_data    = '0;
   logic [SLOTS-1:0] slot_full  = '0;
   logic             dump_done  = 1'b0;
   logic             in_ready;
   logic [SLOTS-1:0] slot_write_en;
   logic [DW-1:0]    slot_write_data;
   logic             begin_dump;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   hybrid_buffer_writer #(
      .BUFFER_SLOTS(SLOTS),
      .MAX_PULSES_PER_SLOT(MAXP),
      .DATA_WIDTH(DW)
   ) dut (
      .core_clk(core_clk),
      .resetn(resetn),
      .fill_start(fill_start),
      .fill_limit(fill_limit),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .slot_full(slot_full),
      .slot_write_en(slot_write_en),
      .slot_write_data(slot_write_data),
      .begin_dump(begin_dump),
      .dump_done(dump_done),
      .busy(busy)
   );

   always #5 core_clk = ~core_clk;

   task automatic step();
      @(posedge core_clk);
      #1;
   endtask

   task automatic test_reset();
      #1 resetn = 1'b0;
      #1;
      step();
      checks++;
      if ({in_ready, begin_dump, busy, slot_write_en, slot_write_data} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got rdy=%b dump=%b busy=%b en=%b data=%h, expected all zero",
                  in_ready, begin_dump, busy, slot_write_en, slot_write_data);
      end
      resetn = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      logic [SLOTS-1:0] exp_en;
      logic [DW-1:0]    slot2 [$];
      fill_start = 1'b1;
      fill_limit = LW'(3);
      step();
      fill_start = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_start: got rdy=%b busy=%b, expected 1 1", in_ready, busy);
      end
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(i);
         step();
         exp_en = SLOTS'(1) << (i % SLOTS);
         if (slot_write_en[2]) slot2.push_back(slot_write_data);
         checks++;
         if (slot_write_en !== exp_en || slot_write_data !== DW'(i)) begin
            failures++;
            $display("[TB] FAIL b2b_beat%0d: got en=%b data=%0d, expected en=%b data=%0d",
                     i, slot_write_en, slot_write_data, exp_en, i);
         end
      end
      in_valid = 1'b0;
      checks++;
      if (slot2.size() != 3 || slot2[0] !== 32'd2 || slot2[1] !== 32'd6 || slot2[2] !== 32'd10) begin
         failures++;
         $display("[TB] FAIL b2b_slot2: got %0d entries, expected 2,6,10", slot2.size());
      end
      checks++;
      if (in_ready !== 1'b0 || begin_dump !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_t1: got rdy=%b dump=%b, expected 0 0", in_ready, begin_dump);
      end
      step();
      checks++;
      if (begin_dump !== 1'b1 || slot_write_en !== '0) begin
         failures++;
         $display("[TB] FAIL b2b_t2_dump: got dump=%b en=%b, expected 1 0000", begin_dump, slot_write_en);
      end
      step();
      checks++;
      if (begin_dump !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_drain: got dump=%b busy=%b, expected 0 1", begin_dump, busy);
      end
      dump_done = 1'b1;
      step();
      dump_done = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_idle: got busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_toggle_valid();
      logic [SLOTS-1:0] exp_en;
      int beat = 0;
      fill_start = 1'b1;
      fill_limit = LW'(3);
      step();
      fill_start = 1'b0;
      for (int cyc = 0; cyc < 40 && beat < 12; cyc++) begin
         in_valid  = (cyc % 2 == 0);
         in_data   = in_valid ? DW'(beat) : 32'hDEAD_BEEF;
         dump_done = (cyc == 1);
         step();
         exp_en = in_valid ? (SLOTS'(1) << (beat % SLOTS)) : '0;
         checks++;
         if (slot_write_en !== exp_en || (in_valid && slot_write_data !== DW'(beat))) begin
            failures++;
            $display("[TB] FAIL toggle_cyc%0d: got en=%b data=%0d, expected en=%b data=%0d",
                     cyc, slot_write_en, slot_write_data, exp_en, beat);
         end
         if (in_valid) beat++;
      end
      in_valid  = 1'b0;
      dump_done = 1'b0;
      checks++;
      if (beat != 12 || begin_dump !== 1'b0) begin
         failures++;
         $display("[TB] FAIL toggle_end: got beats=%0d dump=%b, expected 12 0", beat, begin_dump);
      end
      step();
      checks++;
      if (begin_dump !== 1'b1) begin
         failures++;
         $display("[TB] FAIL toggle_dump: got dump=%b, expected 1", begin_dump);
      end
      dump_done = 1'b1;
      step();
      dump_done = 1'b0;
   endtask

   task automatic test_zero_limit();
      fill_start = 1'b1;
      fill_limit = '0;
      step();
      fill_start = 1'b0;
      in_valid   = 1'b1;
      in_data    = 32'd55;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (busy !== 1'b0 || in_ready !== 1'b0 || slot_write_en !== '0) begin
            failures++;
            $display("[TB] FAIL zero_limit%0d: got busy=%b rdy=%b en=%b, expected 0 0 0000",
                     k, busy, in_ready, slot_write_en);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_drain_ignore();
      fill_start = 1'b1;
      fill_limit = LW'(1);
      step();
      fill_start = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(20 + i);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      fill_start = 1'b1;
      fill_limit = LW'(2);
      in_valid   = 1'b1;
      in_data    = 32'd77;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (slot_write_en !== '0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drain_hold%0d: got en=%b rdy=%b busy=%b, expected 0000 0 1",
                     k, slot_write_en, in_ready, busy);
         end
      end
      dump_done = 1'b1;
      step();
      dump_done  = 1'b0;
      fill_start = 1'b0;
      in_valid   = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || slot_write_en !== '0) begin
         failures++;
         $display("[TB] FAIL drain_no_refill: got busy=%b en=%b, expected 0 0000", busy, slot_write_en);
      end
      fill_start = 1'b1;
      fill_limit = LW'(1);
      step();
      fill_start = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL drain_restart: got busy=%b rdy=%b, expected 1 1", busy, in_ready);
      end
      for (int i = 0; i < SLOTS; i++) begin
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      dump_done = 1'b1;
      step();
      dump_done = 1'b0;
   endtask

   task automatic test_reset_mid_fill();
      logic [SLOTS-1:0] exp_en;
      fill_start = 1'b1;
      fill_limit = LW'(3);
      step();
      fill_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(i);
         step();
      end
      in_valid = 1'b0;
      resetn   = 1'b0;
      #1;
      checks++;
      if ({in_ready, begin_dump, busy, slot_write_en, slot_write_data} !== '0) begin
         failures++;
         $display("[TB] FAIL midreset_async: got rdy=%b dump=%b busy=%b en=%b data=%h, expected all zero",
                  in_ready, begin_dump, busy, slot_write_en, slot_write_data);
      end
      step();
      resetn = 1'b1;
      step();
      fill_start = 1'b1;
      fill_limit = LW'(1);
      step();
      fill_start = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(100 + i);
         step();
         exp_en = SLOTS'(1) << i;
         checks++;
         if (slot_write_en !== exp_en || slot_write_data !== DW'(100 + i)) begin
            failures++;
            $display("[TB] FAIL midreset_refill%0d: got en=%b data=%0d, expected en=%b data=%0d",
                     i, slot_write_en, slot_write_data, exp_en, 100 + i);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (begin_dump !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midreset_dump: got dump=%b, expected 1", begin_dump);
      end
      dump_done = 1'b1;
      step();
      dump_done = 1'b0;
   endtask

`ifdef HYBRID_BUFFER_WRITER_BACKPRESSURE_EN
   task automatic test_backpressure();
      logic [SLOTS-1:0] exp_en;
      fill_start = 1'b1;
      fill_limit = LW'(1);
      step();
      fill_start = 1'b0;
      in_valid   = 1'b1;
      in_data    = 32'd10;
      step();
      slot_full = 4'b0010;
      in_data   = 32'd11;
      #1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_stall_rdy%0d: got rdy=%b, expected 0", k, in_ready);
         end
         step();
         checks++;
         if (slot_write_en !== '0) begin
            failures++;
            $display("[TB] FAIL bp_stall_en%0d: got en=%b, expected 0000", k, slot_write_en);
         end
      end
      slot_full = '0;
      #1;
      for (int i = 1; i < SLOTS; i++) begin
         in_data = DW'(10 + i);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_rdy%0d: got rdy=%b, expected 1", i, in_ready);
         end
         step();
         exp_en = SLOTS'(1) << i;
         checks++;
         if (slot_write_en !== exp_en || slot_write_data !== DW'(10 + i)) begin
            failures++;
            $display("[TB] FAIL bp_beat%0d: got en=%b data=%0d, expected en=%b data=%0d",
                     i, slot_write_en, slot_write_data, exp_en, 10 + i);
         end
      end
      in_valid = 1'b0;
      step();
      dump_done = 1'b1;
      step();
      dump_done = 1'b0;
   endtask
`else
   task automatic test_full_ignored();
      logic [SLOTS-1:0] exp_en;
      slot_full  = '1;
      fill_start = 1'b1;
      fill_limit = LW'(1);
      step();
      fill_start = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(40 + i);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_ignored_rdy%0d: got rdy=%b, expected 1", i, in_ready);
         end
         step();
         exp_en = SLOTS'(1) << i;
         checks++;
         if (slot_write_en !== exp_en || slot_write_data !== DW'(40 + i)) begin
            failures++;
            $display("[TB] FAIL full_ignored_beat%0d: got en=%b data=%0d, expected en=%b data=%0d",
                     i, slot_write_en, slot_write_data, exp_en, 40 + i);
         end
      end
      in_valid  = 1'b0;
      slot_full = '0;
      step();
      dump_done = 1'b1;
      step();
      dump_done = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_toggle_valid();
      test_zero_limit();
      test_drain_ignore();
      test_reset_mid_fill();
`ifdef HYBRID_BUFFER_WRITER_BACKPRESSURE_EN
      test_backpressure();
`else
      test_full_ignored();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
